// File: rtl/rv32i_encoder_pkg.sv
// Shared RV32I definitions: opcode classes, ALU op numbering, reject reasons,
// plus helpers that map an ALU op onto funct3/funct7 for R/I and BRANCH formats.
package rv32i_encoder_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_NE   = 4'd11;
    localparam logic [3:0] OP_GE   = 4'd12;
    localparam logic [3:0] OP_GEU  = 4'd13;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_OPCODE = 3'd1,
        ERR_OP     = 3'd2,
        ERR_RANGE  = 3'd3,
        ERR_ALIGN  = 3'd4
    } err_code_t;

    typedef struct packed {
        logic       ok;
        logic       alt;
        logic [2:0] f3;
    } alu_enc_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] f3;
    } br_enc_t;

    // alt selects the inst[30] variant (SUB/SRA)
    function automatic alu_enc_t alu_enc(input logic [3:0] op);
        alu_enc_t r;
        r = '{ok: 1'b1, alt: 1'b0, f3: 3'b000};
        case (op)
            OP_ADD:  r.f3 = 3'b000;
            OP_SUB:  begin r.f3 = 3'b000; r.alt = 1'b1; end
            OP_SLT:  r.f3 = 3'b010;
            OP_SLTU: r.f3 = 3'b011;
            OP_XOR:  r.f3 = 3'b100;
            OP_OR:   r.f3 = 3'b110;
            OP_AND:  r.f3 = 3'b111;
            OP_SLL:  r.f3 = 3'b001;
            OP_SRL:  r.f3 = 3'b101;
            OP_SRA:  begin r.f3 = 3'b101; r.alt = 1'b1; end
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

    function automatic br_enc_t br_enc(input logic [3:0] op);
        br_enc_t r;
        r = '{ok: 1'b1, f3: 3'b000};
        case (op)
            OP_EQ:   r.f3 = 3'b000;
            OP_NE:   r.f3 = 3'b001;
            OP_SLT:  r.f3 = 3'b100;
            OP_GE:   r.f3 = 3'b101;
            OP_SLTU: r.f3 = 3'b110;
            OP_GEU:  r.f3 = 3'b111;
            default: r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_enc_fifo.sv
// Synchronous FIFO for encoded words; pointers carry an extra wrap bit so
// full/empty/level fall out of a plain subtraction.
module rv32i_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PW'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // storage is reset so the head word reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/rv32i_encoder.sv
// Field-bundle to RV32I word encoder with output FIFO and sequential addresses.
// Define RV32I_ENC_RANGE_CHECK_EN to reject out-of-range / misaligned immediates.
module rv32i_encoder
    import rv32i_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [6:0]                     in_opcode,
    input  logic [3:0]                     in_op,
    input  logic [2:0]                     in_funct3,
    input  logic [4:0]                     in_rd,
    input  logic [4:0]                     in_rs1,
    input  logic [4:0]                     in_rs2,
    input  logic [31:0]                    in_imm,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_inst,
    output logic [31:0]                    out_addr,
    input  logic                           restart,
    input  logic                           clear_err,
    output logic                           err,
    output logic [2:0]                     err_code,
    output logic [ERR_CNT_W-1:0]           err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    logic [XLEN-1:0] enc_inst;
    err_code_t       enc_err;
    err_code_t       err_code_q;
    alu_enc_t        alu;
    br_enc_t         br;
    logic            is_shift;
    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;
    logic            reject;

    assign alu      = alu_enc(in_op);
    assign br       = br_enc(in_op);
    assign is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);

`ifdef RV32I_ENC_RANGE_CHECK_EN
    err_code_t imm_err;
    logic      fit12;
    logic      fit13;
    logic      fit21;

    assign fit12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
    assign fit13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
    assign fit21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

    // range is judged before alignment when both are wrong
    always_comb begin
        imm_err = ERR_NONE;
        case (in_opcode)
            I_TYPE: begin
                if (is_shift ? (in_imm[31:5] != '0) : !fit12) imm_err = ERR_RANGE;
            end
            LOAD, STORE, JALR, SYSTEM: begin
                if (!fit12) imm_err = ERR_RANGE;
            end
            BRANCH: begin
                if (!fit13)        imm_err = ERR_RANGE;
                else if (in_imm[0]) imm_err = ERR_ALIGN;
            end
            JAL: begin
                if (!fit21)        imm_err = ERR_RANGE;
                else if (in_imm[0]) imm_err = ERR_ALIGN;
            end
            LUI, AUIPC: begin
                if (in_imm[11:0] != '0) imm_err = ERR_ALIGN;
            end
            default: ;
        endcase
    end
`endif

    // word packing is the exact inverse of the decoder's immediate extraction
    always_comb begin
        enc_inst = '0;
        enc_err  = ERR_NONE;
        case (in_opcode)
            R_TYPE: begin
                if (!alu.ok) enc_err = ERR_OP;
                enc_inst = {1'b0, alu.alt, 5'b0, in_rs2, in_rs1, alu.f3, in_rd, in_opcode};
            end
            I_TYPE: begin
                if (!alu.ok || (in_op == OP_SUB)) enc_err = ERR_OP;
                if (is_shift) begin
                    enc_inst = {1'b0, alu.alt, 5'b0, in_imm[4:0], in_rs1, alu.f3, in_rd, in_opcode};
                end else begin
                    enc_inst = {in_imm[11:0], in_rs1, alu.f3, in_rd, in_opcode};
                end
            end
            LOAD, SYSTEM, FENCE: begin
                enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            JALR: begin
                enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
            end
            STORE: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            BRANCH: begin
                if (!br.ok) enc_err = ERR_OP;
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br.f3,
                            in_imm[4:1], in_imm[11], in_opcode};
            end
            JAL: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            LUI, AUIPC: begin
                enc_inst = {in_imm[31:12], in_rd, in_opcode};
            end
            default: enc_err = ERR_OPCODE;
        endcase
`ifdef RV32I_ENC_RANGE_CHECK_EN
        if (enc_err == ERR_NONE) enc_err = imm_err;
`endif
    end

    assign in_ready = !full && !restart;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (enc_err == ERR_NONE);
    assign reject   = accept && (enc_err != ERR_NONE);
    assign out_valid = !empty;
    assign pop      = out_valid && out_ready && !restart;
    assign err_code = err_code_q;

    rv32i_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (push),
        .pop   (pop),
        .wdata (enc_inst),
        .rdata (out_inst),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // head address tracking and sticky reject status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr   <= BASE_ADDR;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
            err_cnt    <= '0;
        end else begin
            if (restart) begin
                out_addr <= BASE_ADDR;
            end else if (pop) begin
                out_addr <= out_addr + 32'd4;
            end
            if (reject) begin
                err <= 1'b1;
                if (!err) err_code_q <= enc_err;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
            end else if (clear_err) begin
                err        <= 1'b0;
                err_code_q <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Randomized bench for rv32i_encoder against a field-arithmetic reference model,
// plus directed encodings, full/restart, error and mid-stream reset cases.
module tb_rv32i_encoder;

`ifdef RV32I_ENC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [3:0]  in_op;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        restart;
    logic        clear_err;
    logic        err;
    logic [2:0]  err_code;
    logic [7:0]  err_cnt;
    logic [2:0]  fifo_level;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    logic [31:0] m_addr;
    int          m_err;
    int          m_code;
    int          m_cnt;

    logic [31:0] alu_f3 [10] = '{0, 0, 2, 3, 4, 6, 7, 1, 5, 5};
    logic [6:0]  opc_tbl [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                  7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};

    rv32i_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_op(in_op), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .restart(restart), .clear_err(clear_err),
        .err(err), .err_code(err_code), .err_cnt(err_cnt), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: fields are placed by shift-and-add from the ISA bit positions
    function automatic void ref_encode(input logic [6:0] opc, input logic [3:0] op,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm,
                                       output logic [31:0] w, output int code);
        int s;
        logic [31:0] o, d, a, b, f, alt, bf;
        bit big12;
        s     = $signed(imm);
        o     = 32'(opc);
        d     = 32'(rd) << 7;
        a     = 32'(rs1) << 15;
        b     = 32'(rs2) << 20;
        f     = 32'(f3) << 12;
        alt   = (op == 1 || op == 9) ? 32'h4000_0000 : 32'h0;
        big12 = (s < -2048) || (s > 2047);
        w     = 32'h0;
        code  = 0;
        bf    = 32'h0;
        case (opc)
            7'h33: begin
                if (op > 9) code = 2;
                else w = alt + b + a + (alu_f3[int'(op)] << 12) + d + o;
            end
            7'h13: begin
                if (op > 9 || op == 1) code = 2;
                else if (op >= 7) begin
                    w = alt + ((imm & 32'd31) << 20) + a + (alu_f3[int'(op)] << 12) + d + o;
                    if (RANGE_EN && imm > 32'd31) code = 3;
                end else begin
                    w = ((imm & 32'hFFF) << 20) + a + (alu_f3[int'(op)] << 12) + d + o;
                    if (RANGE_EN && big12) code = 3;
                end
            end
            7'h03, 7'h73, 7'h0F, 7'h67: begin
                w = ((imm & 32'hFFF) << 20) + a + ((opc == 7'h67) ? 32'h0 : f) + d + o;
                if (RANGE_EN && opc != 7'h0F && big12) code = 3;
            end
            7'h23: begin
                w = (((imm >> 5) & 32'h7F) << 25) + b + a + f + ((imm & 32'd31) << 7) + o;
                if (RANGE_EN && big12) code = 3;
            end
            7'h63: begin
                case (op)
                    4'd10: bf = 0;
                    4'd11: bf = 1;
                    4'd2:  bf = 4;
                    4'd12: bf = 5;
                    4'd3:  bf = 6;
                    4'd13: bf = 7;
                    default: code = 2;
                endcase
                w = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + b + a + (bf << 12)
                  + (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7) + o;
                if (RANGE_EN && code == 0 && (s < -4096 || s > 4095)) code = 3;
                if (RANGE_EN && code == 0 && imm[0]) code = 4;
            end
            7'h6F: begin
                w = (((imm >> 20) & 1) << 31) + (((imm >> 1) & 1023) << 21)
                  + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 255) << 12) + d + o;
                if (RANGE_EN && (s < -1048576 || s > 1048575)) code = 3;
                if (RANGE_EN && code == 0 && imm[0]) code = 4;
            end
            7'h37, 7'h17: begin
                w = (imm & 32'hFFFF_F000) + d + o;
                if (RANGE_EN && (imm & 32'hFFF) != 0) code = 4;
            end
            default: code = 1;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [6:0] opc, input logic [3:0] op,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm,
                         input logic ordy, input logic rst, input logic clr);
        in_valid = v; in_opcode = opc; in_op = op; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        out_ready = ordy; restart = rst; clear_err = clr;
    endtask

    task automatic idle(input logic ordy, input logic rst, input logic clr);
        drive(1'b0, 7'h0, 4'h0, 3'h0, 5'h0, 5'h0, 5'h0, 32'h0, ordy, rst, clr);
    endtask

    // compare outputs at the falling edge, then advance the model across the rising edge
    task automatic cycle();
        logic [31:0] w;
        int  code;
        bit  rdy, acc, pp;
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) check_eq("out_inst", out_inst, q[0]);
        check_eq("out_addr", out_addr, m_addr);
        check_eq("fifo_level", 32'(fifo_level), 32'(q.size()));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("err_code", 32'(err_code), 32'(m_code));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
        rdy = (q.size() < DEPTH) && !restart;
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        pp  = (q.size() > 0) && out_ready && !restart;
        ref_encode(in_opcode, in_op, in_funct3, in_rd, in_rs1, in_rs2, in_imm, w, code);
        @(posedge clk);
        #1;
        if (restart) begin
            q.delete();
            m_addr = 32'h0;
        end else begin
            if (pp) begin
                void'(q.pop_front());
                m_addr += 32'd4;
            end
            if (acc && code == 0) q.push_back(w);
        end
        if (acc && code != 0) begin
            if (m_err == 0) m_code = code;
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
        end else if (clear_err) begin
            m_err  = 0;
            m_code = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " out_valid"}, 32'(out_valid), 32'h0);
        check_eq({tag, " out_inst"}, out_inst, 32'h0);
        check_eq({tag, " out_addr"}, out_addr, 32'h0);
        check_eq({tag, " err"}, 32'(err), 32'h0);
        check_eq({tag, " err_code"}, 32'(err_code), 32'h0);
        check_eq({tag, " err_cnt"}, 32'(err_cnt), 32'h0);
        check_eq({tag, " fifo_level"}, 32'(fifo_level), 32'h0);
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = 32'h0;
        m_err  = 0;
        m_code = 0;
        m_cnt  = 0;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return $urandom & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 40));
        endcase
    endfunction

    function automatic logic [6:0] rand_opc();
        if ($urandom_range(0, 11) == 0) return 7'($urandom);
        return opc_tbl[$urandom_range(0, 10)];
    endfunction

    initial begin
        rst_n = 1'b0;
        idle(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed encodings
        drive(1, 7'h33, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 0, 0, 0); cycle();
        check_eq("add word", out_inst, 32'h002081B3);
        check_eq("add addr", out_addr, 32'h0);
        drive(1, 7'h33, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 0, 0, 0); cycle();
        idle(1'b1, 1'b0, 1'b0); cycle();
        check_eq("sub word", out_inst, 32'h402081B3);
        check_eq("sub addr", out_addr, 32'h4);
        drive(1, 7'h13, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 0, 0); cycle();
        check_eq("addi word", out_inst, 32'hFFF00093);
        drive(1, 7'h13, 4'd9, 3'd0, 5'd5, 5'd6, 5'd0, 32'd3, 1, 0, 0); cycle();
        check_eq("srai word", out_inst, 32'h40335293);
        drive(1, 7'h63, 4'd10, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 0, 0); cycle();
        check_eq("beq word", out_inst, 32'h00208463);
        drive(1, 7'h6F, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1, 0, 0); cycle();
        check_eq("jal word", out_inst, 32'h001000EF);
        idle(1'b1, 1'b0, 1'b0); cycle();

        // rejects
        drive(1, 7'h13, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 0, 0); cycle();
        if (RANGE_EN) begin
            check_eq("range err", 32'(err), 32'h1);
            check_eq("range code", 32'(err_code), 32'h3);
            check_eq("range cnt", 32'(err_cnt), 32'h1);
        end
        drive(1, 7'h63, 4'd10, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1, 0, 0); cycle();
        if (RANGE_EN) begin
            check_eq("align code kept", 32'(err_code), 32'h3);
            check_eq("align cnt", 32'(err_cnt), 32'h2);
        end
        drive(1, 7'h13, 4'd1, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1, 0, 0); cycle();
        check_eq("op err", 32'(err), 32'h1);
        check_eq("op code", 32'(err_code), RANGE_EN ? 32'h3 : 32'h2);
        check_eq("op cnt", 32'(err_cnt), RANGE_EN ? 32'h3 : 32'h1);
        idle(1'b1, 1'b0, 1'b1); cycle();
        check_eq("clear err", 32'(err), 32'h0);
        check_eq("clear code", 32'(err_code), 32'h0);
        check_eq("clear keeps cnt", 32'(err_cnt), RANGE_EN ? 32'h3 : 32'h1);

        // fill, back-pressure, restart
        idle(1'b0, 1'b1, 1'b0); cycle();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 7'h33, 4'd0, 3'd0, 5'(i), 5'd1, 5'd2, 32'h0, 0, 0, 0); cycle();
        end
        check_eq("full level", 32'(fifo_level), 32'd4);
        idle(1'b0, 1'b0, 1'b0);
        #1;
        check_eq("full ready", 32'(in_ready), 32'h0);
        idle(1'b1, 1'b0, 1'b0); cycle();
        check_eq("pop level", 32'(fifo_level), 32'd3);
        check_eq("pop ready", 32'(in_ready), 32'h1);
        idle(1'b1, 1'b1, 1'b0); cycle();
        check_eq("restart level", 32'(fifo_level), 32'd0);
        check_eq("restart addr", out_addr, 32'h0);
        check_eq("restart valid", 32'(out_valid), 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), rand_opc(), 4'($urandom_range(0, 15)),
                  3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 29) == 0));
            cycle();
        end

        // asynchronous reset with three entries queued
        idle(1'b0, 1'b1, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 7'h37, 4'd0, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'h1234_5000, 0, 0, 0); cycle();
        end
        check_eq("pre-reset level", 32'(fifo_level), 32'd3);
        idle(1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 7'h17, 4'd0, 3'd0, 5'(i), 5'd0, 5'd0, 32'h0000_1000, 1, 0, 0); cycle();
        end
        idle(1'b1, 1'b0, 1'b0); cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
